// File: rtl/sort_engine_iter.sv
// Iterative odd-even transposition sorter: one shared compare-exchange layer per clock,
// valid/ready on both sides, runtime direction, stable ordering and original-index tags.
module sort_engine_iter #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_CNT   = 16,
    parameter int EARLY_EXIT = 1,
    localparam int IDX_W     = (DATA_CNT > 2) ? $clog2(DATA_CNT) : 1,
    localparam int PH_W      = $clog2(DATA_CNT + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_dir,
    input  logic [DATA_WIDTH*DATA_CNT-1:0] in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH*DATA_CNT-1:0] out_data,
    output logic [IDX_W*DATA_CNT-1:0]     out_idx,
    output logic [PH_W-1:0]               out_phases
);

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t                state_reg;
    logic                  dir_reg;
    logic                  swap_prev_reg;
    logic [PH_W-1:0]       phase_reg;
    logic [DATA_WIDTH-1:0] key_reg [DATA_CNT];
    logic [IDX_W-1:0]      idx_reg [DATA_CNT];

    logic [DATA_WIDTH-1:0] key_next [DATA_CNT];
    logic [IDX_W-1:0]      idx_next [DATA_CNT];
    logic [DATA_WIDTH*DATA_CNT-1:0] key_next_flat;
    logic [IDX_W*DATA_CNT-1:0]      idx_next_flat;
    logic [DATA_CNT-2:0]   swap;
    logic                  swap_cur;
    logic                  last_phase;
    logic                  early_stop;
    logic                  accept;

    // Pair (gi, gi+1) is active when its left element parity matches the phase parity.
    // Strict comparisons keep equal keys in place, which is what makes the sort stable.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_CNT - 1; gi++) begin : g_cmp
            assign swap[gi] = (phase_reg[0] == 1'(gi % 2)) &&
                              (dir_reg ? (key_reg[gi] < key_reg[gi+1])
                                       : (key_reg[gi] > key_reg[gi+1]));
        end

        // Active pairs never overlap within a phase, so each element takes at most one neighbour.
        for (gi = 0; gi < DATA_CNT; gi++) begin : g_xchg
            if (gi == 0) begin : g_first
                assign key_next[gi] = swap[gi] ? key_reg[gi+1] : key_reg[gi];
                assign idx_next[gi] = swap[gi] ? idx_reg[gi+1] : idx_reg[gi];
            end else if (gi == DATA_CNT - 1) begin : g_last
                assign key_next[gi] = swap[gi-1] ? key_reg[gi-1] : key_reg[gi];
                assign idx_next[gi] = swap[gi-1] ? idx_reg[gi-1] : idx_reg[gi];
            end else begin : g_mid
                assign key_next[gi] = swap[gi]   ? key_reg[gi+1] :
                                      swap[gi-1] ? key_reg[gi-1] : key_reg[gi];
                assign idx_next[gi] = swap[gi]   ? idx_reg[gi+1] :
                                      swap[gi-1] ? idx_reg[gi-1] : idx_reg[gi];
            end
            assign key_next_flat[gi*DATA_WIDTH +: DATA_WIDTH] = key_next[gi];
            assign idx_next_flat[gi*IDX_W +: IDX_W]           = idx_next[gi];
        end
    endgenerate

    assign swap_cur   = |swap;
    assign last_phase = (phase_reg == PH_W'(DATA_CNT - 1));
    assign early_stop = (EARLY_EXIT != 0) && (phase_reg != '0) && !swap_cur && !swap_prev_reg;
    assign accept     = (state_reg == IDLE) && in_valid && !flush;

    // Key/index storage carries no reset: it is always loaded on accept before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < DATA_CNT; i++) begin
                key_reg[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
                idx_reg[i] <= IDX_W'(i);
            end
        end else if (state_reg == SORT && !flush) begin
            for (int i = 0; i < DATA_CNT; i++) begin
                key_reg[i] <= key_next[i];
                idx_reg[i] <= idx_next[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_idx       <= '0;
            out_phases    <= '0;
            dir_reg       <= 1'b0;
            phase_reg     <= '0;
            swap_prev_reg <= 1'b1;
        end else if (flush) begin
            state_reg <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        state_reg     <= SORT;
                        in_ready      <= 1'b0;
                        dir_reg       <= in_dir;
                        phase_reg     <= '0;
                        swap_prev_reg <= 1'b1;
                    end
                end
                SORT: begin
                    if (last_phase || early_stop) begin
                        state_reg  <= DONE;
                        out_valid  <= 1'b1;
                        out_data   <= key_next_flat;
                        out_idx    <= idx_next_flat;
                        out_phases <= phase_reg + 1'b1;
                    end else begin
                        phase_reg     <= phase_reg + 1'b1;
                        swap_prev_reg <= swap_cur;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_engine_iter.sv
// Directed bench for sort_engine_iter (W=8, N=4): table of jobs plus hand-written
// backpressure, flush and mid-job reset sequences.
module tb_sort_engine_iter;

    localparam int W = 8;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid, in_valid_ne;
    logic        in_dir;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [7:0]  out_idx;
    logic [2:0]  out_phases;

    logic        ne_in_ready, ne_out_valid;
    logic [31:0] ne_out_data;
    logic [7:0]  ne_out_idx;
    logic [2:0]  ne_out_phases;

    logic        sel;
    logic        cur_in_ready, cur_out_valid;
    logic [31:0] cur_out_data;
    logic [7:0]  cur_out_idx;
    logic [2:0]  cur_out_phases;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sort_engine_iter #(.DATA_WIDTH(W), .DATA_CNT(N), .EARLY_EXIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_dir(in_dir), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_phases(out_phases)
    );

    sort_engine_iter #(.DATA_WIDTH(W), .DATA_CNT(N), .EARLY_EXIT(0)) dut_ne (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid_ne), .in_ready(ne_in_ready), .in_dir(in_dir), .in_data(in_data),
        .out_valid(ne_out_valid), .out_ready(out_ready), .out_data(ne_out_data),
        .out_idx(ne_out_idx), .out_phases(ne_out_phases)
    );

    assign cur_in_ready   = sel ? ne_in_ready   : in_ready;
    assign cur_out_valid  = sel ? ne_out_valid  : out_valid;
    assign cur_out_data   = sel ? ne_out_data   : out_data;
    assign cur_out_idx    = sel ? ne_out_idx    : out_idx;
    assign cur_out_phases = sel ? ne_out_phases : out_phases;

    typedef struct {
        logic        ne;
        logic        dir;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic [7:0]  exp_idx;
        int          exp_phases;
    } vec_t;

    vec_t tbl [5];

    function automatic logic [31:0] k4(input logic [7:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [7:0] i4(input logic [1:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic accept_job(input logic ne, input logic dir, input logic [31:0] data);
        int n = 0;
        sel = ne;
        @(negedge clk);
        in_data = data;
        in_dir  = dir;
        if (ne) in_valid_ne = 1'b1; else in_valid = 1'b1;
        while (!cur_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cur_in_ready) check("accept_timeout", 32'(cur_in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        in_valid_ne = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!cur_out_valid && n < 40);
        if (!cur_out_valid) check("done_timeout", 32'(cur_out_valid), 32'd1);
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_hs_out_valid", 32'(cur_out_valid), 32'd0);
        check("post_hs_in_ready", 32'(cur_in_ready), 32'd1);
    endtask

    task automatic run_job(input vec_t v);
        int lat;
        accept_job(v.ne, v.dir, v.data);
        wait_done(lat);
        check("latency", 32'(lat), 32'(v.exp_phases));
        check("out_data", cur_out_data, v.exp_data);
        check("out_idx", 32'(cur_out_idx), 32'(v.exp_idx));
        check("out_phases", 32'(cur_out_phases), 32'(v.exp_phases));
        $display("job ee=%0d dir=%0d in=%h -> out=%h idx=%h phases=%0d lat=%0d",
                 !v.ne, v.dir, v.data, cur_out_data, cur_out_idx, cur_out_phases, lat);
        handshake();
    endtask

    initial begin
        int  lat;
        logic bad;

        tbl[0] = '{1'b0, 1'b0, k4(3,1,2,0), k4(0,1,2,3), i4(3,1,2,0), 4};
        tbl[1] = '{1'b0, 1'b0, k4(1,2,3,4), k4(1,2,3,4), i4(0,1,2,3), 2};
        tbl[2] = '{1'b1, 1'b0, k4(1,2,3,4), k4(1,2,3,4), i4(0,1,2,3), 4};
        tbl[3] = '{1'b0, 1'b1, k4(5,5,2,7), k4(7,5,5,2), i4(3,0,1,2), 4};
        tbl[4] = '{1'b0, 1'b0, k4(9,8,7,6), k4(6,7,8,9), i4(3,2,1,0), 4};

        sel = 1'b0; rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_valid_ne = 1'b0;
        in_dir = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_phases", 32'(out_phases), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);

        for (int i = 0; i < 4; i++) run_job(tbl[i]);

        // Backpressure: hold DONE for 10 cycles with a new job waiting
        accept_job(1'b0, 1'b0, k4(3,1,2,0));
        wait_done(lat);
        @(negedge clk);
        in_data  = k4(1,2,3,4);
        in_valid = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (out_data !== k4(0,1,2,3) || out_idx !== i4(3,1,2,0) ||
                out_phases !== 3'd4 || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
        end
        check("bp_stable", 32'(bad), 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_queued_taken", 32'(in_ready), 32'd0);
        wait_done(lat);
        check("bp_queued_lat", 32'(lat), 32'd2);
        check("bp_queued_data", out_data, k4(1,2,3,4));
        $display("job backpressure queued -> out=%h phases=%0d lat=%0d", out_data, out_phases, lat);
        handshake();

        // Flush at phase 1
        accept_job(1'b0, 1'b0, k4(3,1,2,0));
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        check("flush_no_valid", 32'(bad), 32'd0);
        $display("job flushed at phase 1");

        // Flush in IDLE beats a pending in_valid
        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_idle_not_taken", 32'(in_ready), 32'd1);

        // Asynchronous reset mid-SORT
        accept_job(1'b0, 1'b0, k4(3,1,2,0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_phases", 32'(out_phases), 32'd0);
        check("arst_out_data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("job reset mid-sort");

        run_job(tbl[4]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
